s2q_dispatcher: RTL and testbench

- Downstream counterpart of the quad-to-single uplink path: receives GMII frames from the upper link and steers each frame to one of four channel outputs.
- Strips the preamble and SFD, then checks the destination MAC. The top 46 bits must equal the local prefix; bits [1:0] of the last MAC byte select the channel.
- Frames that fail the check are dropped and counted.
- Sits between the upper GMII RX and per-channel transmit buffers, which are separate blocks.

---
 rtl/s2q_pkg.sv | 31 +++
 rtl/s2q_dispatcher_if.sv | 22 ++
 rtl/s2q_delay_line.sv | 39 +++
 rtl/s2q_dispatcher.sv | 157 +++++++++++++++
 tb/tb_s2q_dispatcher.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/s2q_pkg.sv
// s2q_pkg: shared state encoding, framing constants and delay-line entry type
// for the single-to-quad GMII dispatcher.
package s2q_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      HDR,
      FWD,
      DROP
   } state_t;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;
   localparam int         HDR_LEN       = 6;
   localparam int         DLY           = 7;
   localparam int         MAX_PRE       = 15;

   // One byte travelling through the delay line with its frame markers.
   typedef struct packed {
      logic [7:0] data;
      logic       tag;
      logic       last;
      logic       err;
   } dly_ent_t;

   function automatic logic [3:0] onehot4(input logic [1:0] sel);
      return 4'b0001 << sel;
   endfunction

endpackage

// File: rtl/s2q_dispatcher_if.sv
// s2q_dispatcher_if: upper-link GMII receive side plus the shared channel
// output bus. The dispatcher is the slave; the upstream/downstream side is the master.
interface s2q_dispatcher_if;
   logic [7:0] gmii_rxd;
   logic       gmii_rx_dv;
   logic       gmii_rx_er;
   logic [7:0] ch_data;
   logic [3:0] ch_valid;
   logic       ch_sof;
   logic       ch_eof;
   logic       ch_err;

   modport master (
      output gmii_rxd, gmii_rx_dv, gmii_rx_er,
      input  ch_data, ch_valid, ch_sof, ch_eof, ch_err
   );

   modport slave (
      input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
      output ch_data, ch_valid, ch_sof, ch_eof, ch_err
   );
endinterface

// File: rtl/s2q_delay_line.sv
// s2q_delay_line: fixed-length tagged shift register. The end-of-frame marker
// is only known one cycle after a byte enters, so it is folded in on the
// stage0 -> stage1 transfer.
module s2q_delay_line
   import s2q_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_tag,
   input  logic       set_last,
   input  logic       set_err,
   output dly_ent_t   tail
);

   dly_ent_t stg [DLY];
   dly_ent_t s1_in;

   // Stage-1 input: previous byte plus the now-resolved last/err markers.
   always_comb begin
      s1_in      = stg[0];
      s1_in.last = set_last;
      s1_in.err  = set_last & set_err;
   end

   // Free-running shift; advances every clock regardless of data validity.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DLY; i++) stg[i] <= '0;
      end else begin
         stg[0] <= '{data: in_data, tag: in_tag, last: 1'b0, err: 1'b0};
         stg[1] <= s1_in;
         for (int i = 2; i < DLY; i++) stg[i] <= stg[i-1];
      end
   end

   assign tail = stg[DLY-1];

endmodule

// File: rtl/s2q_dispatcher.sv
// s2q_dispatcher: strips preamble/SFD from the upper GMII RX stream, checks the
// destination MAC prefix and steers each accepted frame to one of four channels
// after a fixed 7-cycle delay. Rejected frames are dropped and counted.
module s2q_dispatcher
   import s2q_pkg::*;
#(
   parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_00,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   s2q_dispatcher_if.slave  bus,
   output logic [CNT_W-1:0] fwd_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   state_t      state, state_n;
   logic [3:0]  pre_cnt;
   logic [2:0]  hdr_idx;
   logic [39:0] mac_sr;
   logic        err_pend;
   logic        armed;
   logic        fwd_en;
   logic [1:0]  ch_sel;
   logic        out_busy;

   logic        tag_in, last_set, hdr_done, runt, sfd_seen;
   logic        mac_hit, er_now, emit;
   dly_ent_t    tail;

   assign mac_hit = ({mac_sr, bus.gmii_rxd[7:2]} == LOCAL_MAC[47:2]);
   assign er_now  = bus.gmii_rx_er & ((state == HDR) || (state == FWD));
   assign emit    = tail.tag & fwd_en;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Next-state and per-byte tagging decisions.
   always_comb begin
      state_n  = state;
      tag_in   = 1'b0;
      last_set = 1'b0;
      hdr_done = 1'b0;
      runt     = 1'b0;
      sfd_seen = 1'b0;
      case (state)
         IDLE: begin
            // Until rx_dv has been seen low after reset, treat data as a frame tail.
            if (bus.gmii_rx_dv)
               state_n = (armed && bus.gmii_rxd == PREAMBLE_BYTE) ? PRE : DROP;
         end
         PRE: begin
            if (!bus.gmii_rx_dv) begin
               state_n = IDLE;
            end else if (bus.gmii_rxd == SFD_BYTE) begin
               state_n  = HDR;
               sfd_seen = 1'b1;
            end else if (bus.gmii_rxd == PREAMBLE_BYTE && pre_cnt < 4'(MAX_PRE)) begin
               state_n = PRE;
            end else begin
               state_n = DROP;
            end
         end
         HDR: begin
            if (!bus.gmii_rx_dv) begin
               runt    = 1'b1;
               state_n = IDLE;
            end else begin
               tag_in = 1'b1;
               if (hdr_idx == 3'(HDR_LEN-1)) begin
                  hdr_done = 1'b1;
                  state_n  = mac_hit ? FWD : DROP;
               end
            end
         end
         FWD: begin
            if (!bus.gmii_rx_dv) begin
               last_set = 1'b1;
               state_n  = IDLE;
            end else begin
               tag_in = 1'b1;
            end
         end
         DROP: begin
            if (!bus.gmii_rx_dv) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Input-side bookkeeping: preamble length, header capture, error latch, drops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_cnt  <= '0;
         hdr_idx  <= '0;
         mac_sr   <= '0;
         err_pend <= 1'b0;
         armed    <= 1'b0;
         drop_cnt <= '0;
      end else begin
         armed   <= armed | ~bus.gmii_rx_dv;
         pre_cnt <= (state == PRE) ? pre_cnt + 4'd1 : 4'd1;
         hdr_idx <= (state == HDR) ? hdr_idx + 3'd1 : 3'd0;
         if (state == HDR) mac_sr <= {mac_sr[31:0], bus.gmii_rxd};
         if (sfd_seen)    err_pend <= 1'b0;
         else if (er_now) err_pend <= 1'b1;
         if (((hdr_done && !mac_hit) || runt) && drop_cnt != '1)
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

   s2q_delay_line u_dly (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (bus.gmii_rxd),
      .in_tag   (tag_in),
      .set_last (last_set),
      .set_err  (err_pend | er_now),
      .tail     (tail)
   );

   // Output stage and per-frame steering; the header decision is made well
   // after the previous frame's eof has drained, so it takes priority.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.ch_data  <= '0;
         bus.ch_valid <= '0;
         bus.ch_sof   <= 1'b0;
         bus.ch_eof   <= 1'b0;
         bus.ch_err   <= 1'b0;
         fwd_en       <= 1'b0;
         ch_sel       <= '0;
         out_busy     <= 1'b0;
         fwd_cnt      <= '0;
      end else begin
         bus.ch_data  <= tail.data;
         bus.ch_valid <= emit ? onehot4(ch_sel) : 4'b0000;
         bus.ch_sof   <= emit & ~out_busy;
         bus.ch_eof   <= emit & tail.last;
         bus.ch_err   <= emit & tail.last & tail.err;
         if (emit) out_busy <= ~tail.last;
         if (emit && tail.last) begin
            fwd_en <= 1'b0;
            ch_sel <= '0;
            if (fwd_cnt != '1) fwd_cnt <= fwd_cnt + 1'b1;
         end
         if (hdr_done) begin
            fwd_en <= mac_hit;
            ch_sel <= mac_hit ? bus.gmii_rxd[1:0] : 2'b00;
         end
      end
   end

endmodule

// File: tb/tb_s2q_dispatcher.sv
// tb_s2q_dispatcher: directed scenarios plus randomized frames, checked against
// a frame-level scoreboard of expected output beats with their emission cycle.
module tb_s2q_dispatcher;
   import s2q_pkg::*;

   localparam int          CW  = 4;
   localparam logic [47:0] MAC = 48'h02_00_00_00_00_00;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] fwd_cnt, drop_cnt;

   s2q_dispatcher_if bus();

   s2q_dispatcher #(.LOCAL_MAC(MAC), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .fwd_cnt  (fwd_cnt),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         t;
      logic [7:0] d;
      logic [3:0] v;
      logic       sof, eof, err;
   } beat_t;

   beat_t exp_q[$];
   int    ecnt = 0;
   int    total = 0, bad = 0;
   int    m_fwd = 0, m_drop = 0;

   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h edge=%0d", tag, act, exp, ecnt);
      end
   endtask

   function automatic int sat(input int n);
      return (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
   endfunction

   // Output monitor: each edge either carries the scheduled beat or nothing.
   always @(negedge clk) begin
      beat_t b;
      b = '{t: 0, d: 8'h00, v: 4'h0, sof: 1'b0, eof: 1'b0, err: 1'b0};
      if (exp_q.size() > 0 && exp_q[0].t == ecnt) b = exp_q.pop_front();
      chk("valid", bus.ch_valid, b.v);
      chk("sof", bus.ch_sof, b.sof);
      chk("eof", bus.ch_eof, b.eof);
      chk("err", bus.ch_err, b.err);
      if (b.v != 4'h0) chk("data", bus.ch_data, b.d);
   end

   task automatic drive(input logic dv, input logic [7:0] d, input logic er, input logic rn);
      bus.gmii_rx_dv = dv;
      bus.gmii_rxd   = d;
      bus.gmii_rx_er = er;
      rst_n          = rn;
      @(posedge clk);
      #1;
   endtask

   // Body = destination MAC then payload; mode 0 matches, 1 breaks the
   // prefix in bytes 0..4, 2 breaks bits [7:2] of byte 5.
   task automatic make_body(input logic [1:0] ch, input int len, input int mode,
                            output logic [7:0] b[$]);
      logic [47:0] mac_v;
      logic [7:0]  by;
      mac_v = MAC;
      b = {};
      for (int i = 0; i < len; i++) begin
         if (i < 5)       by = mac_v[47-8*i -: 8];
         else if (i == 5) by = {mac_v[7:2], ch};
         else             by = 8'($urandom);
         b.push_back(by);
      end
      if (mode == 1 && len > 0)
         b[$urandom_range(0, (len < 5 ? len : 5) - 1)] ^= 8'(1 << $urandom_range(0, 7));
      if (mode == 2 && len > 5) b[5] ^= 8'(4 << $urandom_range(0, 5));
   endtask

   task automatic send_frame(input int ifg, input int npre, input logic [7:0] body[$],
                             input int er_idx, input int rst_idx);
      logic [47:0] mac_v;
      int          len;
      bit          hit, fwd, has_er, cut;
      logic [1:0]  ch;
      mac_v  = MAC;
      len    = body.size();
      hit    = (len >= 6);
      for (int i = 0; i < 6 && hit; i++) begin
         if (i < 5) hit = (body[i] == mac_v[47-8*i -: 8]);
         else       hit = (body[5][7:2] == mac_v[7:2]);
      end
      fwd    = (npre <= MAX_PRE) && hit;
      ch     = (len >= 6) ? body[5][1:0] : 2'b00;
      has_er = (er_idx >= 0) && (er_idx < len);
      cut    = 1'b0;
      repeat (ifg)  drive(1'b0, 8'h00, 1'b0, 1'b1);
      repeat (npre) drive(1'b1, PREAMBLE_BYTE, 1'b0, 1'b1);
      drive(1'b1, SFD_BYTE, 1'b0, 1'b1);
      for (int i = 0; i < len; i++) begin
         if (i == rst_idx) begin
            drive(1'b1, body[i], 1'b0, 1'b0);
            while (exp_q.size() > 0 && exp_q[$].t >= ecnt) void'(exp_q.pop_back());
            m_fwd  = 0;
            m_drop = 0;
            cut    = 1'b1;
         end else begin
            if (fwd && !cut)
               exp_q.push_back('{t: ecnt + 1 + DLY, d: body[i], v: 4'b0001 << ch,
                                 sof: (i == 0), eof: (i == len - 1),
                                 err: (i == len - 1) && has_er});
            drive(1'b1, body[i], (i == er_idx), 1'b1);
         end
      end
      if (!cut && npre <= MAX_PRE) begin
         if (hit) m_fwd++;
         else     m_drop++;
      end
   endtask

   task automatic chk_cnt(input string tag);
      repeat (12) drive(1'b0, 8'h00, 1'b0, 1'b1);
      chk({tag, "_fwd_cnt"}, 32'(fwd_cnt), 32'(sat(m_fwd)));
      chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(sat(m_drop)));
   endtask

   initial begin
      logic [7:0] b[$];
      int         len, mode, npre, er;
      bus.gmii_rx_dv = 1'b0;
      bus.gmii_rxd   = 8'h00;
      bus.gmii_rx_er = 1'b0;
      rst_n          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.ch_valid), 32'h0);
      chk("rst_fwd_cnt", 32'(fwd_cnt), 32'h0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);

      // 1: 60-byte frame to channel 2
      make_body(2'd2, 60, 0, b);
      send_frame(2, 7, b, -1, -1);
      chk_cnt("t1");

      // 2: prefix mismatch 02:00:00:00:01:03
      make_body(2'd3, 60, 0, b);
      b[4] = 8'h01;
      send_frame(2, 7, b, -1, -1);
      chk_cnt("t2");

      // 3: back-to-back, minimum IFG and preamble, channels 0 then 3
      make_body(2'd0, 40, 0, b);
      send_frame(1, 1, b, -1, -1);
      make_body(2'd3, 40, 0, b);
      send_frame(1, 1, b, -1, -1);
      chk_cnt("t3");

      // 4: rx_er at byte 20 of a 64-byte frame to channel 1
      make_body(2'd1, 64, 0, b);
      send_frame(2, 7, b, 20, -1);
      chk_cnt("t4");

      // 5: runt after 4 header bytes, then a good frame to channel 2
      make_body(2'd2, 4, 0, b);
      send_frame(2, 7, b, -1, -1);
      make_body(2'd2, 50, 0, b);
      send_frame(1, 2, b, -1, -1);
      chk_cnt("t5");

      // 6: reset at byte 30, then a normal frame
      make_body(2'd1, 60, 0, b);
      send_frame(2, 7, b, -1, 30);
      make_body(2'd0, 30, 0, b);
      send_frame(2, 7, b, -1, -1);
      chk_cnt("t6");

      // random frames; enough drops and forwards to hit counter saturation
      for (int f = 0; f < 60; f++) begin
         len  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : $urandom_range(6, 40);
         mode = $urandom_range(0, 3);
         if (mode == 3) mode = 0;
         npre = ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(1, 15);
         er   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 45) : -1;
         make_body(2'($urandom), len, mode, b);
         send_frame($urandom_range(1, 4), npre, b, er, -1);
      end
      chk_cnt("rand");
      chk("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
